// File: rtl/dmem_wbuf_pkg.sv
// dmem_wbuf_pkg
//   Shared types and constants for the data-memory posted-store buffer.
//   wbuf_entry_t : one queued store {addr, data}; fields are sized at the
//                  widest supported address/data width (32 bits), and narrower
//                  top-level AW/DW values are zero-extended into them.
//   DEPTH_DEFAULT: default number of store entries.
//   WORD_LSB     : lowest address bit that takes part in word matching.
package dmem_wbuf_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int WORD_LSB      = 2;
    localparam int ENTRY_AW      = 32;
    localparam int ENTRY_DW      = 32;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [ENTRY_DW-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_match.sv
// wbuf_match
//   Word-address match of a load against the pending store entries.
//   Reports whether any valid entry matches and which one is the youngest.
//   Ports:
//     entries   in  DEPTH x wbuf_entry_t  store storage, indexed by slot
//     valid     in  DEPTH                 slot holds a pending store
//     head      in  PW                    slot of the oldest entry
//     load_addr in  ENTRY_AW              load byte address
//     hit       out 1                     at least one valid slot matches
//     hit_idx   out PW                    slot of the youngest matching entry
module wbuf_match
    import dmem_wbuf_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int PW    = $clog2(DEPTH)
) (
    input  wbuf_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]        valid,
    input  logic [PW-1:0]           head,
    input  logic [ENTRY_AW-1:0]     load_addr,
    output logic                    hit,
    output logic [PW-1:0]           hit_idx
);

    logic [DEPTH-1:0] match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match[i] = valid[i] &&
            (entries[i].addr[ENTRY_AW-1:WORD_LSB] == load_addr[ENTRY_AW-1:WORD_LSB]);
    end

    // Walk slots from oldest (head) to youngest; the last match seen wins,
    // which gives the youngest store in program order.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[head + PW'(k)]) begin
                hit     = 1'b1;
                hit_idx = head + PW'(k);
            end
        end
    end

    // Store data and byte offsets do not take part in matching.
    logic unused_ok;
    assign unused_ok = ^{entries, load_addr[WORD_LSB-1:0]};

endmodule

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
//   Posted-store buffer between the core's data-memory port and the data
//   memory. Stores are queued in a DEPTH-entry FIFO and drained one per
//   cycle in which the memory accepts; loads go straight to the memory read
//   port, with store-to-load forwarding from pending entries.
//
//   Build option: define WBUF_FORWARD_EN to forward the youngest matching
//   pending store to a load. Without it, a load matching any pending store
//   stalls until the matching entries have drained and always returns
//   mem_rdata.
//
//   Ports:
//     clk, reset              clock; synchronous active-low reset
//     cpu_we / cpu_re         store / load request from the core
//     cpu_addr, cpu_wdata     byte address, store data
//     cpu_rdata               load data returned to the core
//     fence                   hold the core until the buffer is empty
//     stall                   core holds PC and retries the instruction
//     count                   number of valid entries
//     mem_raddr, mem_rdata    memory read port (combinational read)
//     mem_we, mem_waddr,
//     mem_wdata, mem_wready   memory write port presenting the head entry
//
//   AW and DW may not exceed the package entry widths (32).
module dmem_write_buffer
    import dmem_wbuf_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    parameter  int AW    = 32,
    parameter  int DW    = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          fence,
    output logic          stall,
    output logic [CW-1:0] count,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wready
);

    wbuf_entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [DEPTH-1:0]        valid;
    logic                    hit;
    logic [PW-1:0]           hit_idx;
    logic                    load_hit;
    logic                    load_stall;
    logic                    full;
    logic                    push;
    logic                    pop;

    // ---------------------------------------------------------------
    // Write port: always presents the head entry
    // ---------------------------------------------------------------
    assign mem_we    = (count != '0);
    assign mem_waddr = AW'(entries[head].addr);
    assign mem_wdata = DW'(entries[head].data);
    assign mem_raddr = cpu_addr;

    assign full = (count == CW'(DEPTH));
    assign pop  = mem_we && mem_wready;

    // ---------------------------------------------------------------
    // Valid mask: a slot is live when its distance from head is below
    // count. Pointer subtraction wraps since DEPTH is a power of two.
    // ---------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PW-1:0] age;
        assign age      = PW'(i) - head;
        assign valid[i] = ({1'b0, age} < count);
    end

    wbuf_match #(.DEPTH(DEPTH)) u_match (
        .entries   (entries),
        .valid     (valid),
        .head      (head),
        .load_addr (ENTRY_AW'(cpu_addr)),
        .hit       (hit),
        .hit_idx   (hit_idx)
    );

    assign load_hit = cpu_re && hit;

`ifdef WBUF_FORWARD_EN
    assign load_stall = 1'b0;
    assign cpu_rdata  = load_hit ? DW'(entries[hit_idx].data) : mem_rdata;
`else
    // The load retries until every matching store has reached memory.
    assign load_stall = load_hit;
    assign cpu_rdata  = mem_rdata;

    logic unused_idx;
    assign unused_idx = ^hit_idx;
`endif

    // A full buffer only blocks a store if the head is not leaving this
    // cycle. Combinational on mem_wready by design.
    assign stall = (cpu_we && full && !pop) ||
                   (fence && mem_we)         ||
                   load_stall;

    assign push = cpu_we && !stall;

    // ---------------------------------------------------------------
    // Pointers and occupancy
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is never cleared; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr: ENTRY_AW'(cpu_addr), data: ENTRY_DW'(cpu_wdata)};
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer
//   Self-checking bench for dmem_write_buffer. A queue of pending stores is
//   the reference: stall, forwarding and the head entry are computed from it
//   each cycle and compared against the design. Directed scenarios first,
//   then randomized traffic.
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_we, cpu_re, fence, mem_wready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata, mem_rdata, mem_wdata;
    logic          stall, mem_we;
    logic [CW-1:0] count;
    logic [AW-1:0] mem_raddr, mem_waddr;

    always #5 clk = ~clk;

    dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .fence      (fence),
        .stall      (stall),
        .count      (count),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];     // pending stores, oldest first
    logic [31:0] wlog[$];  // addresses the design actually wrote to memory
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge
    // against the queue model, then advance the model at the rising edge.
    task automatic step(input logic rst, input logic we, input logic re, input logic fn,
                        input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] md);
        logic        e_stall, e_pop, hit;
        logic [31:0] e_rd;
        reset = rst; cpu_we = we; cpu_re = re; fence = fn; mem_wready = wr;
        cpu_addr = a; cpu_wdata = wd; mem_rdata = md;
        @(negedge clk);
        e_pop = (q.size() != 0) && wr;
        hit   = 1'b0;
        e_rd  = md;
        foreach (q[i]) begin
            if (q[i].a[31:2] == a[31:2]) begin
                hit  = 1'b1;
                e_rd = q[i].d;   // later entries are younger
            end
        end
        e_stall = (we && q.size() == DEPTH && !e_pop) || (fn && q.size() != 0);
`ifndef WBUF_FORWARD_EN
        e_stall = e_stall || (re && hit);
        e_rd    = md;
`endif
        chk("count", 64'(count), 64'(q.size()));
        chk("mem_we", 64'(mem_we), 64'(q.size() != 0));
        chk("stall", 64'(stall), 64'(e_stall));
        chk("mem_raddr", 64'(mem_raddr), 64'(a));
        if (q.size() != 0) begin
            chk("mem_waddr", 64'(mem_waddr), 64'(q[0].a));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
        end
        if (re) chk("cpu_rdata", 64'(cpu_rdata), 64'(e_rd));
        if (mem_we && wr) wlog.push_back(mem_waddr);
        @(posedge clk);
        if (!rst) begin
            q.delete();
        end else begin
            if (e_pop) void'(q.pop_front());
            if (we && !e_stall) q.push_back('{a, wd});
        end
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic wr);
        step(1'b1, 1'b1, 1'b0, 1'b0, wr, a, d, $urandom);
    endtask

    task automatic idle(input logic wr);
        step(1'b1, 1'b0, 1'b0, 1'b0, wr, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc;
        reset = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; fence = 1'b0; mem_wready = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);

        // Three stores drain on consecutive cycles
        do_reset();
        wlog.delete();
        st(32'h10, 32'hAA, 1'b1);
        st(32'h14, 32'hBB, 1'b1);
        st(32'h18, 32'hCC, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_nwrites", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) begin
            chk("t1_w0", 64'(wlog[0]), 64'h10);
            chk("t1_w1", 64'(wlog[1]), 64'h14);
            chk("t1_w2", 64'(wlog[2]), 64'h18);
        end

        // Full buffer: 5th store stalls, then goes in with a same-cycle pop
        do_reset();
        for (int i = 0; i < 4; i++) st(32'h100 + 32'(4*i), 32'(i), 1'b0);
        chk("t2_count_full", 64'(count), 64'd4);
        st(32'h110, 32'h5, 1'b0);
        chk("t2_stall", 64'(stall), 64'd1);
        chk("t2_count_stall", 64'(count), 64'd4);
        st(32'h110, 32'h5, 1'b1);
        chk("t2_count_after", 64'(count), 64'd4);
        chk("t2_head", 64'(mem_waddr), 64'h104);

        // Two stores to one word, then a load of it
        do_reset();
        st(32'h20, 32'h1, 1'b0);
        st(32'h20, 32'h2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22, 32'h0, 32'h55);
`ifdef WBUF_FORWARD_EN
        chk("t3_fwd_rdata", 64'(cpu_rdata), 64'h2);
        chk("t3_fwd_stall", 64'(stall), 64'd0);
`else
        chk("t3_haz_stall", 64'(stall), 64'd1);
        cyc = 0;
        while (stall && cyc < 10) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 32'h55);
            cyc++;
        end
        chk("t3_haz_bound", 64'(cyc < 10), 64'd1);
        chk("t3_haz_count", 64'(count), 64'd0);
        chk("t3_haz_rdata", 64'(cpu_rdata), 64'h55);
`endif

        // Load of an address not in the buffer
        do_reset();
        st(32'h20, 32'h7, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h99);
        chk("t4_rdata", 64'(cpu_rdata), 64'h99);
        chk("t4_stall", 64'(stall), 64'd0);

        // Fence with two pending stores, mem_wready 1,0,1
        do_reset();
        st(32'h30, 32'h1, 1'b0);
        st(32'h34, 32'h2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        chk("t5_stall_a", 64'(stall), 64'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("t5_stall_b", 64'(stall), 64'd1);
        chk("t5_count_b", 64'(count), 64'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        chk("t5_count_c", 64'(count), 64'd0);
        chk("t5_stall_c", 64'(stall), 64'd0);

        // Reset with pending stores discards them
        do_reset();
        for (int i = 0; i < 3; i++) st(32'h200 + 32'(4*i), 32'(i + 9), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_mem_we", 64'(mem_we), 64'd0);
        n = wlog.size();
        repeat (3) idle(1'b1);
        chk("t6_no_writes", 64'(wlog.size()), 64'(n));

        // Randomized traffic over a small address window so loads hit often
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_we, r_re;
            logic [31:0] r_a;
            r_rst = ($urandom_range(199) != 0);
            r_we  = ($urandom_range(1) == 1);
            r_re  = ($urandom_range(2) == 0);
            r_a   = 32'h100 + 32'($urandom_range(31));
            step(r_rst, r_we, r_re, ($urandom_range(19) == 0),
                 ($urandom_range(9) < 6), r_a, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Posted-store buffer between the single-cycle MIPS core's data-memory outputs (MemWrite, ALUout, writedata) and the data memory. Stores are queued in a small FIFO and drained to memory one per accepted cycle, so the core never waits on a slow memory write port. Loads bypass the queue to the memory read port, with store-to-load forwarding from pending entries. The core is stalled only when the buffer is full, on a fence, or on a load hazard when forwarding is compiled out.

## Interface
- DEPTH, 4: number of store entries; power of two, at least 2.
- AW, 32: address width.
- DW, 32: data width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 clears state at the next rising edge).
- cpu_we  in  1  store request (core MemWrite).
- cpu_re  in  1  load request (core MemToReg).
- cpu_addr  in  AW  byte address (core ALUout).
- cpu_wdata  in  DW  store data (core writedata).
- cpu_rdata  out  DW  load data returned to the core.
- fence  in  1  hold the core until the buffer is empty.
- stall  out  1  core must hold PC and retry the current instruction.
- count  out  $clog2(DEPTH)+1  valid entries.
- mem_raddr  out  AW  read address, equal to cpu_addr.
- mem_rdata  in  DW  combinational memory read data.
- mem_we  out  1  head entry valid and presented.
- mem_waddr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_wready  in  1  memory accepts the presented write this cycle.

## Operation
- FIFO of {addr, data} entries, with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- Pop: mem_we && mem_wready. The head advances and count decrements.
- Push: cpu_we && !stall. The entry is written at the tail, the tail advances and count increments.
- Push and pop in the same cycle: count unchanged, and both pointers advance.
- Full-with-pop: a push is accepted when count==DEPTH and a pop occurs in the same cycle.
- mem_we = (count != 0). mem_waddr and mem_wdata always show the head entry. mem_wdata is X-free only while mem_we=1.
- Stall sources, OR'd together (combinational):
  - cpu_we && count==DEPTH && !pop
  - fence && count!=0
  - load hazard (see Configuration)
- Forwarding: when cpu_re is high, compare cpu_addr[AW-1:2] against every valid entry.
  - If one or more entries match, cpu_rdata is the data of the youngest matching entry.
  - If none match, cpu_rdata = mem_rdata.
- Entries are word-granular; byte offsets cpu_addr[1:0] are ignored for matching.
- Stores to the same address are never merged. Each store drains in program order.

## Timing
- Reset values: count=0, head=0, tail=0, mem_we=0. stall is 0 unless fence or a full condition is raised by the inputs. Entry storage is not cleared.
- Reset mid-operation discards all pending stores. No write is issued in the cycle after reset.
- A store pushed at edge N appears on mem_we/mem_waddr at edge N, visible in cycle N+1. Minimum store-to-memory latency is 1 cycle.
- Forwarding is combinational, with 0-cycle latency. A store pushed at edge N is forwardable to a load in cycle N+1.
- A store and a load in the same cycle cannot occur, because the core issues one memory operation per instruction. If both are asserted, the load does not see the concurrent store.
- stall depends combinationally on mem_wready. The memory must not derive mem_wready from stall.
- While mem_wready=0, the head stays stable. Both mem_waddr and mem_wdata hold.

## Configuration
- WBUF_FORWARD_EN defined: forwarding as described; loads never stall.
- WBUF_FORWARD_EN undefined:
  - The match logic raises stall on cpu_re whenever any valid entry matches.
  - The core holds until the matching entries drain, and cpu_rdata = mem_rdata always.

## Structure
- Package dmem_wbuf_pkg holds:
  - the wbuf_entry_t struct {addr, data};
  - the DEPTH_DEFAULT constant;
  - the WORD_LSB=2 constant.
- Sub-module wbuf_match: takes the entry array, valid mask, head pointer and load address. It returns hit and youngest-hit index, with age ordering relative to head.

## Test plan
- Three stores (0x10→0xAA, 0x14→0xBB, 0x18→0xCC) with mem_wready=1 → mem_waddr sequence 0x10, 0x14, 0x18 on consecutive cycles; count returns to 0.
- Hold mem_wready=0 and issue 5 stores with DEPTH=4 → stall=1 on the 5th store with count=4. Raise mem_wready → the 5th store is accepted in that cycle and count stays 4.
- Stores 0x20→0x1, then 0x20→0x2, then a load of 0x20 with mem_wready=0:
  - forward enabled → cpu_rdata=0x2;
  - forward disabled → stall until both entries drain, then cpu_rdata=mem_rdata.
- Load of 0x40 while the buffer holds only 0x20 → cpu_rdata=mem_rdata, stall=0.
- fence with 2 pending entries and mem_wready toggling 1,0,1 → stall stays high until count=0, then drops.
- reset=0 with 3 pending entries → after the next edge count=0, mem_we=0, and no further memory writes.
